acq_sequencer: RTL and testbench

- Generates the acquisition timing for one Raman trace series.
- Arms on `start` and waits for each laser-shot trigger.
- After each trigger, counts sample points and then a guard interval, then advances the shot (measure) counter until MEASURES shots are done.
- Sits directly upstream of the Stokes/anti-Stokes switch controller and the accumulator, which consume `cnt_point` and `cnt_measure`.

---
 rtl/acq_pkg.sv | 15 +
 rtl/trig_sync_edge.sv | 26 ++
 rtl/acq_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_acq_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and default sizing for the Raman acquisition sequencer.
package acq_pkg;

    localparam int PT_W             = 11;
    localparam int MEAS_W           = 17;
    localparam int GUARD_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SAMPLE,
        GUARD
    } acq_state_t;

endpackage

// File: rtl/trig_sync_edge.sv
// Synchroniser chain plus registered rising-edge detector for the async laser trigger.
module trig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic trig_edge
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            prev      <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], trig};
            prev      <= sync[SYNC_STAGES-1];
            trig_edge <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition timing sequencer: ARM -> SAMPLE -> GUARD per laser shot, MEASURES shots per series.
// Optional ARM trigger timeout is enabled by defining ACQ_TRIG_TIMEOUT_EN.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int PT_W         = acq_pkg::PT_W,
    parameter int MEAS_W       = acq_pkg::MEAS_W,
    parameter int GUARD_CYCLES = acq_pkg::GUARD_CYCLES_DEF,
    parameter int SYNC_STAGES  = 2
`ifdef ACQ_TRIG_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              trig,
    input  logic [PT_W-1:0]   POINTS,
    input  logic [MEAS_W-1:0] MEASURES,
    output logic [PT_W-1:0]   cnt_point,
    output logic [MEAS_W-1:0] cnt_measure,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
`ifdef ACQ_TRIG_TIMEOUT_EN
    output logic              trig_timeout,
`endif
    output logic              trig_overrun
);

    acq_state_t        state_q, state_n;
    logic [PT_W-1:0]   pt_q, pt_n, pts_q, pts_n;
    logic [MEAS_W-1:0] meas_q, meas_n, mcfg_q, mcfg_n;
    logic              done_q, done_n, cfg_err_q, cfg_err_n, ovr_q, ovr_n;
    logic              trig_edge;
    logic              cfg_bad;
    logic [PT_W-1:0]   guard_last;
`ifdef ACQ_TRIG_TIMEOUT_EN
    logic [19:0]       tmo_q, tmo_n;
    logic              tmo_pulse_q, tmo_pulse_n;
`endif

    trig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .trig_edge(trig_edge)
    );

    // A shot must fit in the point counter, including the guard tail.
    assign cfg_bad = (POINTS == '0) || (MEASURES == '0) ||
                     ((32'(POINTS) + 32'(GUARD_CYCLES)) > ((32'd1 << PT_W) - 32'd1));
    assign guard_last = pts_q + PT_W'(GUARD_CYCLES - 1);

    always_comb begin
        state_n   = state_q;
        pt_n      = pt_q;
        meas_n    = meas_q;
        pts_n     = pts_q;
        mcfg_n    = mcfg_q;
        done_n    = 1'b0;
        cfg_err_n = 1'b0;
        ovr_n     = ovr_q;
`ifdef ACQ_TRIG_TIMEOUT_EN
        tmo_n       = '0;
        tmo_pulse_n = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_n = 1'b1;
                    end else begin
                        pts_n   = POINTS;
                        mcfg_n  = MEASURES;
                        ovr_n   = 1'b0;
                        pt_n    = '0;
                        meas_n  = '0;
                        state_n = ARM;
                    end
                end
            end
            ARM: begin
`ifdef ACQ_TRIG_TIMEOUT_EN
                if (trig_edge) begin
                    state_n = SAMPLE;
                    pt_n    = '0;
                end else if (tmo_q == 20'(TIMEOUT_CYCLES - 1)) begin
                    state_n     = IDLE;
                    pt_n        = '0;
                    meas_n      = '0;
                    tmo_pulse_n = 1'b1;
                end else begin
                    tmo_n = tmo_q + 20'd1;
                end
`else
                if (trig_edge) begin
                    state_n = SAMPLE;
                    pt_n    = '0;
                end
`endif
            end
            SAMPLE: begin
                if (trig_edge) ovr_n = 1'b1;
                pt_n = pt_q + PT_W'(1);
                if (pt_q == pts_q - PT_W'(1)) state_n = GUARD;
            end
            GUARD: begin
                if (trig_edge) ovr_n = 1'b1;
                if (pt_q == guard_last) begin
                    pt_n = '0;
                    if (meas_q == mcfg_q - MEAS_W'(1)) begin
                        meas_n  = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        meas_n  = meas_q + MEAS_W'(1);
                        state_n = ARM;
                    end
                end else begin
                    pt_n = pt_q + PT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides everything outside IDLE, including a simultaneous trigger.
        if (abort && (state_q != IDLE)) begin
            state_n = IDLE;
            pt_n    = '0;
            meas_n  = '0;
            done_n  = 1'b0;
            ovr_n   = ovr_q;
`ifdef ACQ_TRIG_TIMEOUT_EN
            tmo_n       = '0;
            tmo_pulse_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pt_q      <= '0;
            meas_q    <= '0;
            pts_q     <= '0;
            mcfg_q    <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef ACQ_TRIG_TIMEOUT_EN
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            pt_q      <= pt_n;
            meas_q    <= meas_n;
            pts_q     <= pts_n;
            mcfg_q    <= mcfg_n;
            done_q    <= done_n;
            cfg_err_q <= cfg_err_n;
            ovr_q     <= ovr_n;
`ifdef ACQ_TRIG_TIMEOUT_EN
            tmo_q       <= tmo_n;
            tmo_pulse_q <= tmo_pulse_n;
`endif
        end
    end

    assign cnt_point    = pt_q;
    assign cnt_measure  = meas_q;
    assign sample_valid = (state_q == SAMPLE);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign trig_overrun = ovr_q;
`ifdef ACQ_TRIG_TIMEOUT_EN
    assign trig_timeout = tmo_pulse_q;
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed self-checking bench for acq_sequencer (POINTS=4 style shots, GUARD_CYCLES=3).
module tb_acq_sequencer;

    localparam int PT_W   = 11;
    localparam int MEAS_W = 17;
    localparam int GUARD  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              trig = 1'b0;
    logic [PT_W-1:0]   POINTS = '0;
    logic [MEAS_W-1:0] MEASURES = '0;
    logic [PT_W-1:0]   cnt_point;
    logic [MEAS_W-1:0] cnt_measure;
    logic              sample_valid, busy, done, cfg_err, trig_overrun;
`ifdef ACQ_TRIG_TIMEOUT_EN
    logic              trig_timeout;
`endif

    int checks = 0;
    int fails  = 0;

    acq_sequencer #(
        .PT_W(PT_W),
        .MEAS_W(MEAS_W),
        .GUARD_CYCLES(GUARD),
        .SYNC_STAGES(2)
`ifdef ACQ_TRIG_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .trig(trig),
        .POINTS(POINTS),
        .MEASURES(MEASURES),
        .cnt_point(cnt_point),
        .cnt_measure(cnt_measure),
        .sample_valid(sample_valid),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err),
`ifdef ACQ_TRIG_TIMEOUT_EN
        .trig_timeout(trig_timeout),
`endif
        .trig_overrun(trig_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start and lands one cycle later (ARM on acceptance).
    task automatic do_start(input int p, input int m);
        POINTS = PT_W'(p);
        MEASURES = MEAS_W'(m);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One shot of POINTS=4, GUARD=3: cnt_point 0..6, sample_valid on 0..3.
    task automatic do_shot(input int m, input bit last, input bit extra);
        int waited;
        trig = 1'b1;
        waited = 0;
        while (sample_valid !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        checks++;
        if (sample_valid !== 1'b1) begin
            $display("FAIL shot_entry m=%0d: sample_valid=%b, required 1 within 12 cycles", m, sample_valid); fails++;
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cnt_point !== PT_W'(k)) begin
                $display("FAIL shot_point m=%0d k=%0d: cnt_point=%0d, required %0d", m, k, cnt_point, k); fails++;
            end
            checks++;
            if (sample_valid !== (k < 4)) begin
                $display("FAIL shot_valid m=%0d k=%0d: sample_valid=%b, required %b", m, k, sample_valid, (k < 4)); fails++;
            end
            checks++;
            if (cnt_measure !== MEAS_W'(m)) begin
                $display("FAIL shot_measure m=%0d k=%0d: cnt_measure=%0d, required %0d", m, k, cnt_measure, m); fails++;
            end
            checks++;
            if ({busy, done} !== 2'b10) begin
                $display("FAIL shot_busy_done m=%0d k=%0d: busy,done=%b%b, required 10", m, k, busy, done); fails++;
            end
            if (k == 0) trig = 1'b0;
            if (extra && k == 1) trig = 1'b1;
            if (extra && k == 2) trig = 1'b0;
            tick();
        end
        checks++;
        if (last) begin
            if ({done, busy, cnt_measure, cnt_point} !== {2'b10, MEAS_W'(0), PT_W'(0)}) begin
                $display("FAIL series_end: done=%b busy=%b cnt_measure=%0d cnt_point=%0d, required 1 0 0 0",
                         done, busy, cnt_measure, cnt_point); fails++;
            end
        end else begin
            if ({done, busy, sample_valid, cnt_measure, cnt_point} !== {3'b010, MEAS_W'(m + 1), PT_W'(0)}) begin
                $display("FAIL shot_exit m=%0d: done=%b busy=%b sv=%b cnt_measure=%0d cnt_point=%0d, required 0 1 0 %0d 0",
                         m, done, busy, sample_valid, cnt_measure, cnt_point, m + 1); fails++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, done, cfg_err, trig_overrun, sample_valid, cnt_point, cnt_measure} !== '0) begin
            $display("FAIL reset_outputs: busy=%b done=%b cfg_err=%b ovr=%b sv=%b pt=%0d meas=%0d, required all 0",
                     busy, done, cfg_err, trig_overrun, sample_valid, cnt_point, cnt_measure); fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_series();
        do_start(4, 2);
        // Config changes while busy must not affect the running series.
        POINTS = PT_W'(9);
        MEASURES = MEAS_W'(9);
        checks++;
        if ({busy, cfg_err, trig_overrun, cnt_point} !== {3'b100, PT_W'(0)}) begin
            $display("FAIL series_arm: busy=%b cfg_err=%b ovr=%b pt=%0d, required 1 0 0 0",
                     busy, cfg_err, trig_overrun, cnt_point); fails++;
        end
        do_shot(0, 1'b0, 1'b0);
        do_shot(1, 1'b1, 1'b0);
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy); fails++;
        end
    endtask

    task automatic test_cfg_err();
        int pv[4] = '{0, 4, 2045, 2044};
        int mv[4] = '{2, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            do_start(pv[i], mv[i]);
            checks++;
            if (i < 3) begin
                if ({cfg_err, busy} !== 2'b10) begin
                    $display("FAIL cfg_reject p=%0d m=%0d: cfg_err=%b busy=%b, required 1 0", pv[i], mv[i], cfg_err, busy); fails++;
                end
                tick();
                checks++;
                if (cfg_err !== 1'b0) begin
                    $display("FAIL cfg_err_pulse p=%0d: cfg_err=%b, required 0", pv[i], cfg_err); fails++;
                end
            end else begin
                if ({cfg_err, busy} !== 2'b01) begin
                    $display("FAIL cfg_accept_max p=%0d: cfg_err=%b busy=%b, required 0 1", pv[i], cfg_err, busy); fails++;
                end
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    $display("FAIL abort_from_arm: busy=%b, required 0", busy); fails++;
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_start(4, 2);
        checks++;
        if (trig_overrun !== 1'b0) begin
            $display("FAIL overrun_initial: trig_overrun=%b, required 0", trig_overrun); fails++;
        end
        do_shot(0, 1'b0, 1'b1);
        checks++;
        if (trig_overrun !== 1'b1) begin
            $display("FAIL overrun_set: trig_overrun=%b, required 1", trig_overrun); fails++;
        end
        do_shot(1, 1'b1, 1'b0);
        checks++;
        if (trig_overrun !== 1'b1) begin
            $display("FAIL overrun_sticky: trig_overrun=%b, required 1", trig_overrun); fails++;
        end
    endtask

    task automatic test_abort();
        int waited;
        do_start(4, 5);
        checks++;
        if (trig_overrun !== 1'b0) begin
            $display("FAIL overrun_cleared_by_start: trig_overrun=%b, required 0", trig_overrun); fails++;
        end
        do_shot(0, 1'b0, 1'b0);
        trig = 1'b1;
        waited = 0;
        while (sample_valid !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        trig = 1'b0;
        tick();
        tick();
        checks++;
        if ({cnt_point, cnt_measure} !== {PT_W'(2), MEAS_W'(1)}) begin
            $display("FAIL abort_pre: cnt_point=%0d cnt_measure=%0d, required 2 1", cnt_point, cnt_measure); fails++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, done, sample_valid, cnt_point, cnt_measure} !== '0) begin
            $display("FAIL abort_idle: busy=%b done=%b sv=%b pt=%0d meas=%0d, required all 0",
                     busy, done, sample_valid, cnt_point, cnt_measure); fails++;
        end
        repeat (6) tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL abort_stays_idle: busy=%b done=%b, required 0 0", busy, done); fails++;
        end
        do_start(4, 2);
        do_shot(0, 1'b0, 1'b0);
        do_shot(1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_guard();
        int waited;
        do_start(4, 2);
        trig = 1'b1;
        waited = 0;
        while (sample_valid !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        trig = 1'b0;
        repeat (5) tick();
        checks++;
        if ({cnt_point, sample_valid, busy} !== {PT_W'(5), 2'b01}) begin
            $display("FAIL pre_reset_guard: cnt_point=%0d sv=%b busy=%b, required 5 0 1", cnt_point, sample_valid, busy); fails++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cfg_err, trig_overrun, sample_valid, cnt_point, cnt_measure} !== '0) begin
            $display("FAIL async_reset: busy=%b done=%b cfg_err=%b ovr=%b sv=%b pt=%0d meas=%0d, required all 0",
                     busy, done, cfg_err, trig_overrun, sample_valid, cnt_point, cnt_measure); fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        trig = 1'b1;
        repeat (2) tick();
        trig = 1'b0;
        repeat (8) tick();
        checks++;
        if ({busy, sample_valid, trig_overrun} !== 3'b000) begin
            $display("FAIL idle_trig_ignored: busy=%b sv=%b ovr=%b, required 0 0 0", busy, sample_valid, trig_overrun); fails++;
        end
    endtask

`ifdef ACQ_TRIG_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        do_start(4, 2);
        early = 0;
        for (int c = 0; c < 99; c++) begin
            tick();
            if (trig_timeout !== 1'b0 || busy !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            $display("FAIL timeout_early: %0d cycles with trig_timeout or idle, required 0", early); fails++;
        end
        tick();
        checks++;
        if ({trig_timeout, busy} !== 2'b10) begin
            $display("FAIL timeout_pulse: trig_timeout=%b busy=%b, required 1 0", trig_timeout, busy); fails++;
        end
        tick();
        checks++;
        if (trig_timeout !== 1'b0) begin
            $display("FAIL timeout_one_cycle: trig_timeout=%b, required 0", trig_timeout); fails++;
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_series();
        test_cfg_err();
        test_overrun();
        test_abort();
        test_reset_mid_guard();
`ifdef ACQ_TRIG_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
